frame_parity_unit: RTL and testbench
====================================

# frame_parity_unit

Parametrised, registered successor to the single-bit XOR/XNOR gate. It accumulates the parity of every bit across a multi-word frame arriving on a valid/ready stream. It returns a one-entry buffered result with a selectable even (XOR) or odd (XNOR) sense, the frame word count and an overflow flag. It sits between a frame source and any integrity-check or tagging stage that needs one parity bit per frame.

## Interface
- WIDTH, 8: data word width in bits (≥1)
- MAX_WORDS, 16: maximum words per frame; the counter saturates here (≥2)
- CW, $clog2(MAX_WORDS+1): count width (derived, not overridable)

- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = even parity (XOR reduction), 1 = odd parity (XNOR reduction)
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat
- in_data  in  WIDTH  data word
- in_last  in  1  final beat of the frame
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- out_parity  out  1  frame parity (per captured mode)
- out_count  out  CW  words accepted in the frame, saturating at MAX_WORDS
- out_overflow  out  1  frame exceeded MAX_WORDS words

## Operation
- States: IDLE (no frame in progress), ACCUM (frame in progress), HOLD (result buffered).
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD. A beat is accepted when in_valid & in_ready.
- IDLE, beat accepted: acc ← ^in_data; count ← 1; mode captured into mode_q. If in_last is set, go to HOLD, otherwise go to ACCUM.
- ACCUM, beat accepted: acc ← acc ^ (^in_data); count ← min(count+1, MAX_WORDS). If the incremented count would exceed MAX_WORDS, set ovf (sticky for the frame). If in_last is set, go to HOLD.
- Entering HOLD: out_parity ← final_acc ^ mode_q; out_count ← count; out_overflow ← ovf; out_valid ← 1.
- HOLD, out_ready = 1: out_valid ← 0 and the state returns to IDLE. acc, count and ovf clear.
- Parity always covers every accepted bit, including words beyond MAX_WORDS.
- Changes to mode mid-frame have no effect. Only the value at the first beat is used.
- in_data and in_last are ignored when in_valid = 0 or in_ready = 0.
- A one-word frame (in_last on the first beat) is legal: count = 1.

## Timing
- Reset (asynchronous assert, synchronous-release-safe): state = IDLE; in_ready = 1 after reset; out_valid = 0; out_parity = 0; out_count = 0; out_overflow = 0; internal acc, count and ovf = 0.
- Latency: out_valid rises on the clock edge that accepts the in_last beat. It is visible the following cycle.
- out_parity, out_count and out_overflow are stable while out_valid = 1. They hold their last values after handshake until the next result.
- The output handshake completes on an edge with out_valid & out_ready. in_ready returns to 1 the next cycle, so there is a minimum one-cycle bubble between frames.
- Backpressure: out_ready may stay low indefinitely. in_ready stays 0 and no input is lost.
- rst_n asserted mid-frame or in HOLD: the partial frame and buffered result are discarded immediately. No result is emitted for that frame.
- out_ready while out_valid = 0: no effect.

## Configuration
- PARITY_CHECK_EN defined:
  - Adds input exp_parity (1 bit), sampled on the accepted in_last beat.
  - Adds output out_error (1 bit), registered alongside the result: out_error = (final parity ≠ exp_parity).
  - out_error resets to 0 and is stable under the same rules as out_parity.
- PARITY_CHECK_EN undefined: exp_parity and out_error do not exist. The remaining behaviour is identical.

## Test plan
- Even-parity single word: mode=0, in_data=8'hA5 with in_last=1 -> next cycle out_valid=1, out_parity=0, out_count=1, out_overflow=0. Repeat with mode=1 -> out_parity=1.
- Multi-word frame: mode=0, beats 8'h01, 8'h03, 8'hFF(last) (11 ones) -> out_parity=1, out_count=3. Toggling mode during beat 2 leaves the result unchanged.
- Backpressure: hold out_ready=0 for 5 cycles after the result -> out_valid stays 1, in_ready=0, an offered beat is not accepted, and outputs are stable. Raise out_ready -> out_valid drops and in_ready=1 on the next cycle.
- Overflow with MAX_WORDS=4: six beats of 8'h01 (last on the sixth), mode=0 -> out_count=4, out_overflow=1, out_parity=0.
- Reset mid-frame: two beats are accepted, then rst_n pulses low -> all outputs are 0 and in_ready=1. The next frame 8'h80(last) gives out_parity=1, out_count=1, unpolluted by the earlier beats.
- With PARITY_CHECK_EN: frame 8'h07(last), mode=0, exp_parity=0 -> out_parity=1, out_error=1. With exp_parity=1 -> out_error=0.

Source files
------------

// File: rtl/frame_parity_unit_if.sv
// Stream bundle for frame_parity_unit: input beats, mode and buffered result.
// PARITY_CHECK_EN adds exp_parity and out_error.
interface frame_parity_unit_if #(
   parameter int WIDTH     = 8,
   parameter int MAX_WORDS = 16
);
   localparam int CW = $clog2(MAX_WORDS + 1);

   logic             mode;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic             out_parity;
   logic [CW-1:0]    out_count;
   logic             out_overflow;
`ifdef PARITY_CHECK_EN
   logic             exp_parity;
   logic             out_error;
`endif

   modport master (
      output mode, in_valid, in_data, in_last, out_ready,
`ifdef PARITY_CHECK_EN
      output exp_parity,
      input  out_error,
`endif
      input  in_ready, out_valid, out_parity, out_count, out_overflow
   );

   modport slave (
      input  mode, in_valid, in_data, in_last, out_ready,
`ifdef PARITY_CHECK_EN
      input  exp_parity,
      output out_error,
`endif
      output in_ready, out_valid, out_parity, out_count, out_overflow
   );
endinterface

// File: rtl/frame_parity_unit.sv
// Per-frame parity accumulator with one-entry result buffer.
// PARITY_CHECK_EN adds an expected-parity compare and out_error.
module frame_parity_unit #(
   parameter int WIDTH     = 8,
   parameter int MAX_WORDS = 16
) (
   input logic                clk,
   input logic                rst_n,
   frame_parity_unit_if.slave bus
);
   localparam int CW = $clog2(MAX_WORDS + 1);
   localparam logic [CW-1:0] MAXC = CW'(MAX_WORDS);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t        state, nxt;
   logic          acc, ovf, mode_q;
   logic [CW-1:0] count;
   logic          take, beat_par, acc_nxt, mode_eff, par_fin, ovf_nxt;
   logic [CW-1:0] cnt_nxt;

   assign bus.in_ready = (state != HOLD);

   always_comb begin
      nxt      = state;
      take     = bus.in_valid && (state != HOLD);
      beat_par = ^bus.in_data;
      acc_nxt  = beat_par;
      cnt_nxt  = ONE;
      ovf_nxt  = 1'b0;
      mode_eff = bus.mode;
      unique case (state)
         IDLE: begin
            if (take) nxt = bus.in_last ? HOLD : ACCUM;
         end
         ACCUM: begin
            acc_nxt  = acc ^ beat_par;
            mode_eff = mode_q;
            ovf_nxt  = ovf;
            // saturate; the extra word still counts toward parity
            if (count == MAXC) begin
               cnt_nxt = MAXC;
               ovf_nxt = 1'b1;
            end else begin
               cnt_nxt = count + ONE;
            end
            if (take && bus.in_last) nxt = HOLD;
         end
         HOLD: begin
            if (bus.out_ready) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
      par_fin = acc_nxt ^ mode_eff;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc              <= 1'b0;
         count            <= '0;
         ovf              <= 1'b0;
         mode_q           <= 1'b0;
         bus.out_valid    <= 1'b0;
         bus.out_parity   <= 1'b0;
         bus.out_count    <= '0;
         bus.out_overflow <= 1'b0;
`ifdef PARITY_CHECK_EN
         bus.out_error    <= 1'b0;
`endif
      end else if (take) begin
         acc   <= acc_nxt;
         count <= cnt_nxt;
         ovf   <= ovf_nxt;
         if (state == IDLE) mode_q <= bus.mode;
         if (bus.in_last) begin
            bus.out_valid    <= 1'b1;
            bus.out_parity   <= par_fin;
            bus.out_count    <= cnt_nxt;
            bus.out_overflow <= ovf_nxt;
`ifdef PARITY_CHECK_EN
            bus.out_error    <= par_fin ^ bus.exp_parity;
`endif
         end
      end else if (state == HOLD && bus.out_ready) begin
         bus.out_valid <= 1'b0;
         acc           <= 1'b0;
         count         <= '0;
         ovf           <= 1'b0;
      end
   end
endmodule

// File: tb/tb_frame_parity_unit.sv
// Scoreboard bench for frame_parity_unit (MAX_WORDS=4).
// PARITY_CHECK_EN enables the expected-parity tests.
module tb_frame_parity_unit;
   localparam int W  = 8;
   localparam int MW = 4;
   localparam int CW = $clog2(MW + 1);

   typedef struct {
      logic          p;
      logic [CW-1:0] c;
      logic          o;
      logic          e;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   fails = 0;
   res_t sb[$];

   logic          m_acc, m_ovf, m_mode, busy;
   logic [CW-1:0] m_cnt;

   always #5 clk = ~clk;

   frame_parity_unit_if #(.WIDTH(W), .MAX_WORDS(MW)) bus ();

   frame_parity_unit #(.WIDTH(W), .MAX_WORDS(MW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic beat(input logic [7:0] d, input logic l,
                       input logic m, input logic e);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      bus.mode     = m;
`ifdef PARITY_CHECK_EN
      bus.exp_parity = e;
`endif
      while (!bus.in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) begin
         checks++;
         fails++;
         $display("FAIL beat_accept in_ready=%b required=1", bus.in_ready);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (!busy) begin
         m_acc  = 1'b0;
         m_cnt  = '0;
         m_ovf  = 1'b0;
         m_mode = m;
         busy   = 1'b1;
      end
      m_acc = m_acc ^ (($countones(d) % 2) == 1);
      if (m_cnt == CW'(MW)) m_ovf = 1'b1;
      else m_cnt = m_cnt + 1'b1;
      if (l) begin
         sb.push_back('{p: m_acc ^ m_mode, c: m_cnt, o: m_ovf,
                        e: m_acc ^ m_mode ^ e});
         busy = 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic collect(input string nm);
      int   t = 0;
      res_t ex;
      while (!bus.out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (!bus.out_valid) begin
         fails++;
         $display("FAIL %s_valid got=0 required=1", nm);
         return;
      end
      checks++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL %s_sb got=empty required=entry", nm);
         return;
      end
      ex = sb.pop_front();
      checks++;
      if (bus.out_parity !== ex.p) begin
         fails++;
         $display("FAIL %s_parity got=%b required=%b", nm, bus.out_parity, ex.p);
      end
      checks++;
      if (bus.out_count !== ex.c) begin
         fails++;
         $display("FAIL %s_count got=%0d required=%0d", nm, bus.out_count, ex.c);
      end
      checks++;
      if (bus.out_overflow !== ex.o) begin
         fails++;
         $display("FAIL %s_ovf got=%b required=%b", nm, bus.out_overflow, ex.o);
      end
`ifdef PARITY_CHECK_EN
      checks++;
      if (bus.out_error !== ex.e) begin
         fails++;
         $display("FAIL %s_error got=%b required=%b", nm, bus.out_error, ex.e);
      end
`endif
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL %s_release valid=%b ready=%b required=0/1",
                  nm, bus.out_valid, bus.in_ready);
      end
      checks++;
      if (bus.out_parity !== ex.p || bus.out_count !== ex.c) begin
         fails++;
         $display("FAIL %s_hold p=%b c=%0d required=%b/%0d",
                  nm, bus.out_parity, bus.out_count, ex.p, ex.c);
      end
   endtask

   task automatic check_zero(input string nm);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_parity !== 1'b0 ||
          bus.out_count !== '0 || bus.out_overflow !== 1'b0 ||
          bus.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL %s v=%b p=%b c=%0d o=%b r=%b required=0/0/0/0/1", nm,
                  bus.out_valid, bus.out_parity, bus.out_count,
                  bus.out_overflow, bus.in_ready);
      end
`ifdef PARITY_CHECK_EN
      checks++;
      if (bus.out_error !== 1'b0) begin
         fails++;
         $display("FAIL %s_error got=%b required=0", nm, bus.out_error);
      end
`endif
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.mode      = 1'b0;
      bus.out_ready = 1'b0;
`ifdef PARITY_CHECK_EN
      bus.exp_parity = 1'b0;
`endif
      busy  = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset_during");
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("reset_after");
   endtask

   task automatic test_single();
      beat(8'hA5, 1'b1, 1'b0, 1'b0);
      collect("single_even");
      beat(8'hA5, 1'b1, 1'b1, 1'b0);
      collect("single_odd");
   endtask

   task automatic test_multi();
      beat(8'h01, 1'b0, 1'b0, 1'b0);
      beat(8'h03, 1'b0, 1'b1, 1'b0);
      beat(8'hFF, 1'b1, 1'b0, 1'b0);
      collect("multi");
   endtask

   task automatic test_backpressure();
      beat(8'h0F, 1'b0, 1'b1, 1'b0);
      beat(8'h10, 1'b1, 1'b1, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      bus.in_last  = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
             bus.out_parity !== sb[0].p || bus.out_count !== sb[0].c) begin
            fails++;
            $display("FAIL bp_stall v=%b r=%b p=%b c=%0d required=1/0/%b/%0d",
                     bus.out_valid, bus.in_ready, bus.out_parity,
                     bus.out_count, sb[0].p, sb[0].c);
         end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      collect("bp");
      beat(8'h01, 1'b1, 1'b0, 1'b0);
      collect("bp_next");
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 6; i++) beat(8'h01, i == 5, 1'b0, 1'b0);
      collect("overflow");
   endtask

   task automatic test_reset_mid();
      beat(8'h01, 1'b0, 1'b0, 1'b0);
      beat(8'h03, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      busy  = 1'b0;
      #1;
      check_zero("rstmid_during");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("rstmid_after");
      beat(8'h80, 1'b1, 1'b0, 1'b0);
      collect("rstmid_next");
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 15; f++) begin
         int len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++)
            beat(8'($urandom), i == len - 1, 1'($urandom), 1'($urandom));
         collect("b2b");
      end
   endtask

`ifdef PARITY_CHECK_EN
   task automatic test_parity_check();
      beat(8'h07, 1'b1, 1'b0, 1'b0);
      collect("chk_bad");
      beat(8'h07, 1'b1, 1'b0, 1'b1);
      collect("chk_good");
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_backpressure();
      test_overflow();
      test_reset_mid();
      test_back_to_back();
`ifdef PARITY_CHECK_EN
      test_parity_check();
`endif
      checks++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL sb_drain left=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
